// File: rtl/quiz_pkg.sv
// Shared definitions for the quiz buzzer host: FSM encoding, player count and
// the 7-segment glyph table (segments {dp,g,f,e,d,c,b,a}, active-high).
package quiz_pkg;

    localparam int NUM_PLAYERS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        LOCKED  = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Values above 9 never occur in normal operation; they render blank.
    function automatic logic [7:0] seg_decode(input logic [3:0] val);
        case (val)
            4'd0:    seg_decode = 8'h3F;
            4'd1:    seg_decode = 8'h06;
            4'd2:    seg_decode = 8'h5B;
            4'd3:    seg_decode = 8'h4F;
            4'd4:    seg_decode = 8'h66;
            4'd5:    seg_decode = 8'h6D;
            4'd6:    seg_decode = 8'h7D;
            4'd7:    seg_decode = 8'h07;
            4'd8:    seg_decode = 8'h7F;
            4'd9:    seg_decode = 8'h6F;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan.sv
// Scanned 4-digit 7-segment driver: one digit enabled for SCAN_DIV cycles each.
// an and seg_code are registered together; content follows digits with 1 clk lag.
module seg_scan
    import quiz_pkg::*;
#(
    parameter int SCAN_DIV = 100_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0][3:0] digits,
    input  logic [3:0]      blank,
    output logic [3:0]      an,
    output logic [7:0]      seg_code
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic [1:0]    idx_nxt;
    logic          scan_wrap;
    logic [7:0]    seg_nxt;

    assign scan_wrap = (scan_cnt == CW'(SCAN_DIV - 1));

    // an==0 only right after reset: start the scan at digit 0.
    always_comb begin
        idx_nxt = idx;
        if (an == 4'b0000) begin
            idx_nxt = 2'd0;
        end else if (scan_wrap) begin
            idx_nxt = idx + 2'd1;
        end
        seg_nxt = blank[idx_nxt] ? SEG_BLANK : seg_decode(digits[idx_nxt]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
            an       <= 4'b0000;
            seg_code <= 8'h00;
        end else begin
            idx      <= idx_nxt;
            an       <= 4'b0001 << idx_nxt;
            seg_code <= seg_nxt;
            if (an == 4'b0000 || scan_wrap) begin
                scan_cnt <= '0;
            end else begin
                scan_cnt <= scan_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/quiz_host.sv
// Quiz buzzer host: arms players, runs the answer countdown, latches the winner, keeps scores.
// Button edge to FSM effect is 3 clk (2 sync + 1 FSM); display follows one clk later.
module quiz_host
    import quiz_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int ANSWER_SEC = 9,
    parameter int SCAN_DIV   = 100_000,
    parameter int MAX_SCORE  = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn,
    input  logic       btn_start,
    input  logic       btn_ok,
    input  logic       btn_ng,
    output logic [3:0] an,
    output logic [7:0] seg_code,
    output logic [3:0] led_winner,
    output logic       led_timeout
);

    localparam int TW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

    logic [6:0] sync1;
    logic [6:0] sync2;
    logic [2:0] host_prev;
    logic [3:0] btn_s;
    logic       start_p;
    logic       ok_p;
    logic       ng_p;

    state_t          state, state_n;
    logic [3:0]      timer, timer_n;
    logic [TW-1:0]   tick, tick_n;
    logic [1:0]      winner, winner_n;
    logic [3:0]      led_winner_n;
    logic [3:0][3:0] score, score_n;
    logic            tick_wrap;
    logic [1:0]      first;

    logic [3:0][3:0] digits;
    logic [3:0]      blank;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            host_prev <= '0;
        end else begin
            sync1     <= {btn_ng, btn_ok, btn_start, btn};
            sync2     <= sync1;
            host_prev <= sync2[6:4];
        end
    end

    assign btn_s   = sync2[3:0];
    assign start_p = sync2[4] & ~host_prev[0];
    assign ok_p    = sync2[5] & ~host_prev[1];
    assign ng_p    = sync2[6] & ~host_prev[2];

    assign tick_wrap = (tick == TW'(CLK_FREQ - 1));

    // Simultaneous presses resolve to the lowest-numbered player.
    always_comb begin
        if (btn_s[0])      first = 2'd0;
        else if (btn_s[1]) first = 2'd1;
        else if (btn_s[2]) first = 2'd2;
        else               first = 2'd3;
    end

    always_comb begin
        state_n      = state;
        timer_n      = timer;
        tick_n       = tick;
        winner_n     = winner;
        led_winner_n = led_winner;
        score_n      = score;
        case (state)
            IDLE, TIMEOUT: begin
                if (start_p) begin
                    state_n      = ARMED;
                    timer_n      = 4'(ANSWER_SEC);
                    tick_n       = '0;
                    led_winner_n = 4'b0000;
                end
            end
            ARMED: begin
                if (tick_wrap) begin
                    tick_n  = '0;
                    timer_n = timer - 4'd1;
                end else begin
                    tick_n = tick + TW'(1);
                end
                // A press on the very cycle the timer expires still wins.
                if (|btn_s) begin
                    state_n      = LOCKED;
                    winner_n     = first;
                    led_winner_n = 4'b0001 << first;
                end else if (tick_wrap && timer_n == 4'd0) begin
                    state_n = TIMEOUT;
                end
            end
            LOCKED: begin
                if (ok_p && !ng_p) begin
                    state_n = IDLE;
                    if (score[winner] < 4'(MAX_SCORE)) begin
                        score_n[winner] = score[winner] + 4'd1;
                    end
                end else if (ng_p && !ok_p) begin
                    state_n = IDLE;
                    if (score[winner] != 4'd0) begin
                        score_n[winner] = score[winner] - 4'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= 4'd0;
            tick       <= '0;
            winner     <= 2'd0;
            led_winner <= 4'b0000;
            score      <= '0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            tick       <= tick_n;
            winner     <= winner_n;
            led_winner <= led_winner_n;
            score      <= score_n;
        end
    end

    assign led_timeout = (state == TIMEOUT);

    always_comb begin
        digits = score;
        blank  = 4'b0000;
        case (state)
            ARMED, TIMEOUT: begin
                digits    = '0;
                digits[0] = timer;
                blank     = 4'b1110;
            end
            LOCKED: begin
                digits    = '0;
                digits[0] = timer;
                digits[3] = {2'b00, winner} + 4'd1;
                blank     = 4'b0110;
            end
            default: ;
        endcase
    end

    seg_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_seg_scan (
        .clk      (clk),
        .rst_n    (rst_n),
        .digits   (digits),
        .blank    (blank),
        .an       (an),
        .seg_code (seg_code)
    );

endmodule

// File: tb/tb_quiz_host.sv
// Directed bench for quiz_host: vector table for round flow plus hand sequences for timing corners.
module tb_quiz_host;

    localparam logic [7:0] G0 = 8'h3F, G1 = 8'h06, G2 = 8'h5B, G3 = 8'h4F;
    localparam logic [7:0] G4 = 8'h66, G8 = 8'h7F, G9 = 8'h6F;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn;
    logic       btn_start, btn_ok, btn_ng;
    logic [3:0] an;
    logic [7:0] seg_code;
    logic [3:0] led_winner;
    logic       led_timeout;

    int n_vec = 0;
    int n_err = 0;

    quiz_host #(
        .CLK_FREQ   (10),
        .ANSWER_SEC (3),
        .SCAN_DIV   (2),
        .MAX_SCORE  (9)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn         (btn),
        .btn_start   (btn_start),
        .btn_ok      (btn_ok),
        .btn_ng      (btn_ng),
        .an          (an),
        .seg_code    (seg_code),
        .led_winner  (led_winner),
        .led_timeout (led_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] btn;
        logic [2:0] host;      // {ng, ok, start}
        int         wait_cyc;
        logic [3:0] exp_win;
        logic       exp_to;
        int         dig;       // -1: no display check
        logic [7:0] exp_seg;
    } vec_t;

    vec_t vt [8];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic read_digit(input int d, output logic [7:0] s);
        int k;
        k = 0;
        while (an != (4'b0001 << d) && k < 12) begin
            tick(1);
            k++;
        end
        if (an != (4'b0001 << d)) begin
            n_vec++;
            n_err++;
            $display("FAIL scan_digit%0d: an=%b never selected it", d, an);
        end
        s = seg_code;
    endtask

    task automatic pulse(input logic [2:0] host);
        {btn_ng, btn_ok, btn_start} = host;
        tick(1);
        {btn_ng, btn_ok, btn_start} = 3'b000;
    endtask

    task automatic check_digit(input string name, input int d, input logic [7:0] exp);
        logic [7:0] s;
        read_digit(d, s);
        chk(name, {24'h0, s}, {24'h0, exp});
    endtask

    initial begin
        int n;

        rst_n = 1'b0; btn = 4'b0000;
        btn_start = 1'b0; btn_ok = 1'b0; btn_ng = 1'b0;

        //            btn      host    wait win      to    dig exp_seg
        vt[0] = '{4'b0000, 3'b001, 11, 4'b0000, 1'b0, -1, 8'h00};  // open round
        vt[1] = '{4'b0100, 3'b000,  6, 4'b0100, 1'b0,  3, G3};     // player 2 buzzes
        vt[2] = '{4'b0100, 3'b000,  1, 4'b0100, 1'b0,  0, G2};     // timer frozen at 2
        vt[3] = '{4'b0000, 3'b010,  5, 4'b0100, 1'b0,  2, G1};     // ok -> score2=1
        vt[4] = '{4'b0000, 3'b001,  5, 4'b0000, 1'b0, -1, 8'h00};  // new round clears led
        vt[5] = '{4'b1010, 3'b000,  5, 4'b0010, 1'b0,  3, G2};     // tie -> player 1
        vt[6] = '{4'b0000, 3'b100,  5, 4'b0010, 1'b0,  1, G0};     // ng at 0 stays 0
        vt[7] = '{4'b0000, 3'b000,  0, 4'b0010, 1'b0,  2, G1};

        // reset state, then first scan digit right after release
        tick(3);
        chk("rst_an", {28'h0, an}, 32'h0);
        chk("rst_seg", {24'h0, seg_code}, 32'h0);
        chk("rst_winner", {28'h0, led_winner}, 32'h0);
        chk("rst_timeout", {31'h0, led_timeout}, 32'h0);
        rst_n = 1'b1;
        tick(1);
        chk("rel_an", {28'h0, an}, 32'h1);
        chk("rel_seg", {24'h0, seg_code}, {24'h0, G0});

        for (int i = 0; i < 8; i++) begin
            btn = vt[i].btn;
            pulse(vt[i].host);
            tick(vt[i].wait_cyc);
            chk($sformatf("v%0d_winner", i), {28'h0, led_winner}, {28'h0, vt[i].exp_win});
            chk($sformatf("v%0d_timeout", i), {31'h0, led_timeout}, {31'h0, vt[i].exp_to});
            if (vt[i].dig >= 0)
                check_digit($sformatf("v%0d_digit%0d", i, vt[i].dig), vt[i].dig, vt[i].exp_seg);
        end

        // timeout: 3 edges of sync/FSM + 3*10 countdown
        pulse(3'b001);
        n = 1;
        while (!led_timeout && n < 100) begin
            tick(1);
            n++;
        end
        chk("timeout_latency", n, 33);
        check_digit("timeout_digit0", 0, G0);
        btn = 4'b0001;
        tick(6);
        chk("timeout_ignores_btn", {28'h0, led_winner}, 32'h0);
        chk("timeout_held", {31'h0, led_timeout}, 32'h1);
        btn = 4'b0000;

        // start from TIMEOUT, then a start pulse mid-round must not reload the timer
        pulse(3'b001);
        tick(12);
        chk("restart_timeout_clr", {31'h0, led_timeout}, 32'h0);
        pulse(3'b001);
        tick(2);
        btn = 4'b1000;
        tick(6);
        chk("p3_winner", {28'h0, led_winner}, 32'h8);
        check_digit("no_reload_digit0", 0, G2);
        btn = 4'b0000;

        // ok and ng together: ignored, still LOCKED
        pulse(3'b110);
        tick(5);
        check_digit("both_judge_locked", 3, G4);
        pulse(3'b010);
        tick(5);
        check_digit("p3_score", 3, G1);

        // saturation of player 0 after ten correct answers, then one wrong
        for (int r = 0; r < 10; r++) begin
            pulse(3'b001);
            tick(4);
            btn = 4'b0001;
            tick(5);
            btn = 4'b0000;
            pulse(3'b010);
            tick(4);
        end
        check_digit("sat_digit0", 0, G9);
        pulse(3'b001);
        tick(4);
        btn = 4'b0001;
        tick(5);
        btn = 4'b0000;
        pulse(3'b100);
        tick(4);
        check_digit("dec_digit0", 0, G8);

        // press lands on the very cycle the timer reaches 0
        pulse(3'b001);
        tick(29);
        btn = 4'b0010;
        tick(5);
        chk("edge_winner", {28'h0, led_winner}, 32'h2);
        chk("edge_no_timeout", {31'h0, led_timeout}, 32'h0);
        check_digit("edge_digit0", 0, G0);
        btn = 4'b0000;
        pulse(3'b010);
        tick(5);

        // reset mid-ARMED
        pulse(3'b001);
        tick(5);
        rst_n = 1'b0;
        tick(5);
        chk("mid_rst_an", {28'h0, an}, 32'h0);
        chk("mid_rst_seg", {24'h0, seg_code}, 32'h0);
        chk("mid_rst_winner", {28'h0, led_winner}, 32'h0);
        rst_n = 1'b1;
        tick(1);
        chk("mid_rel_an", {28'h0, an}, 32'h1);
        chk("mid_rel_seg", {24'h0, seg_code}, {24'h0, G0});
        check_digit("mid_rst_score1", 1, G0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/quiz_host.md
Name: quiz_host

Overview:
Host-side controller for the 4-player quiz buzzer. The host opens a round, and the block arms the player buttons and runs a per-round answer countdown. It latches the first player to buzz, accepts the host's right/wrong judgement, and keeps per-player scores. It drives the board's scanned 4-digit 7-segment display and status LEDs, and sits at top level alongside the player-side responder logic.

Parameters:
CLK_FREQ, 100_000_000, clk cycles per second tick (set small, e.g. 10, in simulation)
ANSWER_SEC, 9, countdown start value in seconds (1..9)
SCAN_DIV, 100_000, clk cycles each display digit stays enabled
MAX_SCORE, 9, per-player score saturation value (<=9)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous, active-low reset
btn  input  4  player buttons, active-high level, asynchronous, pre-debounced
btn_start  input  1  host "open round" button, active-high level, pre-debounced
btn_ok  input  1  host "answer correct" button
btn_ng  input  1  host "answer wrong" button
an  output  4  digit enables, active-high one-hot
seg_code  output  8  segments {dp,g,f,e,d,c,b,a}, active-high
led_winner  output  4  one-hot latched winner, 0 when none
led_timeout  output  1  high while in TIMEOUT

Behaviour:
- Reset: one clock, synchronous, active-low. Sampled on rising clk; rst_n=0 at an edge forces reset state at that edge, in any state, including mid-round.
- Reset state: state=IDLE, scores all 0, led_winner=0, led_timeout=0, an=4'b0000, seg_code=8'h00, tick/scan counters 0. The first scan digit (an=0001) appears on the first cycle after reset release.
- Input handling: all 7 button inputs pass through a 2-FF synchronizer. Host buttons use rising-edge detect, giving a 1-cycle pulse. Players use synchronized level.
- FSM states: IDLE, ARMED, LOCKED, TIMEOUT.
  - IDLE: start pulse -> ARMED; load timer=ANSWER_SEC, clear tick counter, clear led_winner. Player presses are ignored.
  - ARMED: tick counter counts 0..CLK_FREQ-1. On wrap, timer decrements.
    - If any synchronized btn is high: -> LOCKED. winner = lowest index set; latch led_winner one-hot; freeze timer.
    - Else if timer==0 after a decrement: -> TIMEOUT.
    - A press in the same cycle the timer reaches 0 wins (LOCKED).
  - LOCKED: btn_ok pulse alone -> score[winner] += 1, saturating at MAX_SCORE, -> IDLE. btn_ng pulse alone -> score[winner] -= 1, saturating at 0, -> IDLE. Both pulses in the same cycle are ignored and the state stays LOCKED. led_winner holds until the next start.
  - TIMEOUT: led_timeout=1. A start pulse opens a new round directly (-> ARMED, same actions as from IDLE).
  - Start pulses in ARMED/LOCKED and judge pulses outside LOCKED are ignored.
- Latency: a player edge at an input yields LOCKED and led_winner valid 3 clk later (2 sync + 1 FSM). A host button edge gives its FSM effect 3 clk later. A score update is visible on the display at the next scan of that digit.
- Display content, digit i = an bit i:
  - IDLE: digit i shows score[i].
  - ARMED/TIMEOUT: digit0 shows timer, digits 1..3 blank (seg=0).
  - LOCKED: digit0 shows frozen timer, digit3 shows winner+1 (1..4), digits 1..2 blank.
  - dp is always 0.
- Scan: digit advances every SCAN_DIV cycles, order 0,1,2,3 with wrap to 0. an and seg_code are registered together, with no mismatch cycle.
- Widths: timer 4 bits, scores 4 bits each, winner 2 bits, tick counter $clog2(CLK_FREQ) bits.

Decomposition:
- Shared package/header quiz_pkg: FSM state encoding (IDLE/ARMED/LOCKED/TIMEOUT), 7-seg digit patterns 0..9 and blank, NUM_PLAYERS=4.
- One sub-module seg_scan: scan counter, digit mux, BCD-to-segment decode. Takes four 4-bit digit values plus a blank mask; drives an and seg_code.
- FSM, timer, synchronizers and scores stay in quiz_host.

Test Plan:
- Reset: hold rst_n=0 for 5 clk mid-ARMED -> state IDLE, scores 0, an=0000, seg_code=00; next cycle an=0001 with seg=pattern "0".
- Timeout (CLK_FREQ=10, ANSWER_SEC=3): start, no presses -> after 3*10 cycles (+3 sync) led_timeout=1; digit0 shows 0; player presses are then ignored.
- Win and score: start, btn[2] rises after 12 cycles -> led_winner=0100, digit3 shows "3", digit0 frozen at 2. btn_ok -> IDLE, digit2 shows "1".
- Tie: btn=1010 in the same cycle -> led_winner=0010 (player 1). btn_ng with score 0 -> score stays 0.
- Saturation and illegal inputs: ten ok rounds for player 0 -> digit0 stays "9". btn_ok+btn_ng together in LOCKED -> stays LOCKED. Start pulse in ARMED -> timer not reloaded.
- Boundary: press in the same cycle the timer reaches 0 -> LOCKED, not TIMEOUT, digit0 frozen at 0.
